// File: rtl/sram_controller_pkg.sv
// rtl/sram_controller_pkg.sv - shared types and defaults for the SRAM controller
// Contents:
//   state_t                FSM state enumeration
//   DATA_BASE_DEFAULT      byte address mapped to SRAM word 0
//   ACCESS_CYCLES_DEFAULT  cycles each 16-bit half-access is held
package sram_controller_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RD_LO = 3'd1,
      RD_HI = 3'd2,
      WR_LO = 3'd3,
      WR_HI = 3'd4,
      DONE  = 3'd5
   } state_t;

   localparam int DATA_BASE_DEFAULT     = 1024;
   localparam int ACCESS_CYCLES_DEFAULT = 2;

endpackage

// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - 32-bit load/store port onto a 16-bit asynchronous SRAM
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   wr_en, rd_en             store/load request, held by the pipeline until ready
//   address, write_data      byte address and store data, captured on IDLE exit
//   read_data                load result, held until the next load completes
//   ready                    low freezes the pipeline
//   SRAM_ADDR                half-word address (word*2 + half)
//   SRAM_DQ_out/_in/_oe      split bidirectional data bus
//   SRAM_WE_N, SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N  active-low strobes
module sram_controller
   import sram_controller_pkg::*;
#(
   parameter int ACCESS_CYCLES = ACCESS_CYCLES_DEFAULT,
   parameter int DATA_BASE     = DATA_BASE_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic        rd_en,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        ready,
   output logic [17:0] SRAM_ADDR,
   output logic [15:0] SRAM_DQ_out,
   input  logic [15:0] SRAM_DQ_in,
   output logic        SRAM_DQ_oe,
   output logic        SRAM_WE_N,
   output logic        SRAM_CE_N,
   output logic        SRAM_OE_N,
   output logic        SRAM_UB_N,
   output logic        SRAM_LB_N
);

   localparam logic [3:0] CNT_LAST = 4'(ACCESS_CYCLES - 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [16:0] word_q;
   logic [31:0] wdata_q;
   logic [31:0] read_data_q;

   logic        last_cycle;
   logic        start;
   logic [31:0] addr_off;
   logic        unused_addr_bits;

   // Modular subtraction; only word bits [16:0] reach the SRAM, the rest wrap away.
   assign addr_off         = address - 32'(DATA_BASE);
   assign unused_addr_bits = ^{addr_off[31:19], addr_off[1:0]};

   assign last_cycle = (cnt_q == CNT_LAST);
   assign start      = (state_q == IDLE) && (rd_en || wr_en);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         word_q      <= 17'd0;
         wdata_q     <= 32'd0;
         read_data_q <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (start) begin
            word_q  <= addr_off[18:2];
            wdata_q <= write_data;
         end
         // Each half is sampled at the very end of its hold window.
         if (state_q == RD_LO && last_cycle)
            read_data_q[15:0] <= SRAM_DQ_in;
         if (state_q == RD_HI && last_cycle)
            read_data_q[31:16] <= SRAM_DQ_in;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (wr_en)
               state_d = WR_LO;       // write wins when both are requested
            else if (rd_en)
               state_d = RD_LO;
         end
         RD_LO: if (last_cycle) state_d = RD_HI;
         RD_HI: if (last_cycle) state_d = DONE;
         WR_LO: if (last_cycle) state_d = WR_HI;
         WR_HI: if (last_cycle) state_d = DONE;
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Counter restarts on every state entry and only runs inside access states.
      cnt_d = 4'd0;
      if (state_d == state_q &&
          (state_q == RD_LO || state_q == RD_HI ||
           state_q == WR_LO || state_q == WR_HI))
         cnt_d = cnt_q + 4'd1;
   end

   always_comb begin
      SRAM_ADDR   = 18'd0;
      SRAM_DQ_out = 16'd0;
      SRAM_DQ_oe  = 1'b0;
      SRAM_WE_N   = 1'b1;
      SRAM_CE_N   = 1'b1;
      SRAM_OE_N   = 1'b1;
      SRAM_UB_N   = 1'b1;
      SRAM_LB_N   = 1'b1;
      case (state_q)
         RD_LO, RD_HI: begin
            SRAM_ADDR = {word_q, (state_q == RD_HI)};
            SRAM_OE_N = 1'b0;
            SRAM_CE_N = 1'b0;
            SRAM_UB_N = 1'b0;
            SRAM_LB_N = 1'b0;
         end
         WR_LO, WR_HI: begin
            SRAM_ADDR   = {word_q, (state_q == WR_HI)};
            SRAM_DQ_out = (state_q == WR_HI) ? wdata_q[31:16] : wdata_q[15:0];
            SRAM_DQ_oe  = 1'b1;
            SRAM_WE_N   = 1'b0;
            SRAM_CE_N   = 1'b0;
            SRAM_UB_N   = 1'b0;
            SRAM_LB_N   = 1'b0;
         end
         default: ;
      endcase
   end

   assign read_data = read_data_q;
   assign ready     = ~(rd_en | wr_en) | (state_q == DONE);

endmodule

// File: tb/tb_sram_controller.sv
// tb/tb_sram_controller.sv - directed self-checking bench for sram_controller
module tb_sram_controller;

   logic        clk = 1'b0;
   logic        rst;
   int          total = 0;
   int          bad   = 0;

   // default instance (ACCESS_CYCLES=2)
   logic        wr_en, rd_en;
   logic [31:0] address, write_data, read_data;
   logic        ready;
   logic [17:0] sram_addr;
   logic [15:0] dq_out, dq_in;
   logic        dq_oe, we_n, ce_n, oe_n, ub_n, lb_n;

   // single-cycle instance (ACCESS_CYCLES=1)
   logic        wr_en_b, rd_en_b;
   logic [31:0] address_b, write_data_b, read_data_b;
   logic        ready_b;
   logic [17:0] sram_addr_b;
   logic [15:0] dq_out_b, dq_in_b;
   logic        dq_oe_b, we_n_b, ce_n_b, oe_n_b, ub_n_b, lb_n_b;

   always #5 clk = ~clk;

   sram_controller dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
      .address(address), .write_data(write_data), .read_data(read_data),
      .ready(ready), .SRAM_ADDR(sram_addr), .SRAM_DQ_out(dq_out),
      .SRAM_DQ_in(dq_in), .SRAM_DQ_oe(dq_oe), .SRAM_WE_N(we_n),
      .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
   );

   sram_controller #(.ACCESS_CYCLES(1)) dut_b (
      .clk(clk), .rst(rst), .wr_en(wr_en_b), .rd_en(rd_en_b),
      .address(address_b), .write_data(write_data_b), .read_data(read_data_b),
      .ready(ready_b), .SRAM_ADDR(sram_addr_b), .SRAM_DQ_out(dq_out_b),
      .SRAM_DQ_in(dq_in_b), .SRAM_DQ_oe(dq_oe_b), .SRAM_WE_N(we_n_b),
      .SRAM_CE_N(ce_n_b), .SRAM_OE_N(oe_n_b), .SRAM_UB_N(ub_n_b), .SRAM_LB_N(lb_n_b)
   );

   // SRAM read model: fixed values at half-words 4/5, address-tagged pattern elsewhere.
   function automatic logic [15:0] sram_model(input logic [17:0] a);
      if (a == 18'd4)      return 16'h5678;
      else if (a == 18'd5) return 16'h1234;
      else                 return {8'hA5, a[7:0]};
   endfunction

   assign dq_in   = sram_model(sram_addr);
   assign dq_in_b = sram_model(sram_addr_b);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   logic [7:0] exp_rdy;

   initial begin
      rst = 1'b1;
      wr_en = 0; rd_en = 0; address = 0; write_data = 0;
      wr_en_b = 0; rd_en_b = 0; address_b = 0; write_data_b = 0;
      exp_rdy = 8'b1000_1000;

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", ready, 1);
      chk("rst_we_n", we_n, 1);
      chk("rst_oe", dq_oe, 0);
      chk("rst_ce_n", ce_n, 1);
      chk("rst_oe_n", oe_n, 1);
      chk("rst_addr", sram_addr, 0);
      chk("rst_dq_out", dq_out, 0);
      chk("rst_read_data", read_data, 0);
      cyc; rst = 1'b0;

      // idle with no request
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("idle_ready", ready, 1);
         chk("idle_we_n", we_n, 1);
         chk("idle_oe", dq_oe, 0);
         chk("idle_ce_n", ce_n, 1);
         cyc;
      end

      // write 0xDEADBEEF at 1024; inputs disturbed mid-access
      wr_en = 1; address = 32'd1024; write_data = 32'hDEADBEEF;
      @(negedge clk);
      chk("wr_c0_ready", ready, 0);
      chk("wr_c0_we_n", we_n, 1);
      for (int c = 1; c <= 5; c++) begin
         cyc;
         if (c == 1) begin address = 32'h0BAD_0000; write_data = 32'd0; end
         @(negedge clk);
         if (c <= 4) begin
            chk("wr_ready", ready, 0);
            chk("wr_we_n", we_n, 0);
            chk("wr_oe", dq_oe, 1);
            chk("wr_ce_n", ce_n, 0);
            chk("wr_addr", sram_addr, (c <= 2) ? 32'd0 : 32'd1);
            chk("wr_dq", dq_out, (c <= 2) ? 32'hBEEF : 32'hDEAD);
         end else begin
            chk("wr_done_ready", ready, 1);
            chk("wr_done_we_n", we_n, 1);
            chk("wr_done_oe", dq_oe, 0);
            chk("wr_done_ce_n", ce_n, 1);
         end
      end
      cyc; wr_en = 0;
      @(negedge clk);
      chk("wr_after_ready", ready, 1);
      chk("wr_read_data_kept", read_data, 0);

      // read 1032 -> half-words 4,5
      cyc; rd_en = 1; address = 32'd1032;
      @(negedge clk);
      chk("rd_c0_ready", ready, 0);
      for (int c = 1; c <= 5; c++) begin
         cyc;
         @(negedge clk);
         if (c <= 4) begin
            chk("rd_ready", ready, 0);
            chk("rd_oe_n", oe_n, 0);
            chk("rd_we_n", we_n, 1);
            chk("rd_dq_oe", dq_oe, 0);
            chk("rd_addr", sram_addr, (c <= 2) ? 32'd4 : 32'd5);
         end
         if (c == 3) chk("rd_lo_captured", read_data, 32'h0000_5678);
         if (c == 5) begin
            chk("rd_done_ready", ready, 1);
            chk("rd_data", read_data, 32'h1234_5678);
            chk("rd_done_oe_n", oe_n, 1);
         end
      end
      cyc; rd_en = 0;
      @(negedge clk);
      chk("rd_after_ready", ready, 1);

      // read and write together at 1028 -> write wins, half-words 2,3
      cyc; rd_en = 1; wr_en = 1; address = 32'd1028; write_data = 32'hCAFE_F00D;
      for (int c = 1; c <= 5; c++) begin
         cyc;
         @(negedge clk);
         if (c <= 4) begin
            chk("both_we_n", we_n, 0);
            chk("both_oe_n", oe_n, 1);
            chk("both_addr", sram_addr, (c <= 2) ? 32'd2 : 32'd3);
            chk("both_dq", dq_out, (c <= 2) ? 32'hF00D : 32'hCAFE);
         end else begin
            chk("both_done_ready", ready, 1);
            chk("both_read_data_kept", read_data, 32'h1234_5678);
         end
      end
      cyc; rd_en = 0; wr_en = 0;

      // reset pulse during the first WR_HI cycle
      cyc; wr_en = 1; address = 32'd1024; write_data = 32'h1111_2222;
      cyc; cyc;
      cyc;
      @(negedge clk);
      chk("pre_rst_hi_addr", sram_addr, 1);
      chk("pre_rst_hi_we_n", we_n, 0);
      #1 rst = 1'b1;
      #1;
      chk("midrst_we_n", we_n, 1);
      chk("midrst_oe", dq_oe, 0);
      chk("midrst_ready", ready, 0);
      chk("midrst_addr", sram_addr, 0);
      chk("midrst_read_data", read_data, 0);
      cyc; rst = 1'b0;
      @(negedge clk);
      chk("postrst_idle_ready", ready, 0);
      chk("postrst_idle_we_n", we_n, 1);
      for (int c = 1; c <= 5; c++) begin
         cyc;
         @(negedge clk);
         if (c == 1) begin
            chk("restart_addr", sram_addr, 0);
            chk("restart_dq", dq_out, 32'h2222);
            chk("restart_we_n", we_n, 0);
         end
         if (c == 3) chk("restart_hi_dq", dq_out, 32'h1111);
         if (c == 5) chk("restart_done_ready", ready, 1);
      end
      cyc; wr_en = 0;

      // ACCESS_CYCLES=1: back-to-back reads at 1040 -> half-words 8,9
      cyc; rd_en_b = 1; address_b = 32'd1040;
      for (int c = 0; c <= 7; c++) begin
         if (c > 0) cyc;
         @(negedge clk);
         chk("b2b_ready", ready_b, 32'(exp_rdy[c]));
         if (c == 1 || c == 5) chk("b2b_addr_lo", sram_addr_b, 8);
         if (c == 2 || c == 6) chk("b2b_addr_hi", sram_addr_b, 9);
         if (c == 3 || c == 7) chk("b2b_data", read_data_b, 32'hA509_A508);
         if (c == 4) chk("b2b_gap_ce_n", ce_n_b, 1);
      end
      cyc; rd_en_b = 0;
      @(negedge clk);
      chk("b2b_after_ready", ready_b, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 Parameter ACCESS_CYCLES, default 2, cycles each 16-bit SRAM half-access is held; legal range 1..15.
REQ-002 Parameter DATA_BASE, default 1024, byte address mapped to SRAM word 0.
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock, same as pipeline.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 wr_en  input  1  store request from memory stage, held until ready.
REQ-007 rd_en  input  1  load request from memory stage, held until ready.
REQ-008 address  input  32  byte address (ALU result).
REQ-009 write_data  input  32  store data (val_Rm).
REQ-010 read_data  output  32  load result to memory stage register.
REQ-011 ready  output  1  low = pipeline freeze; high = access complete or no request.
REQ-012 SRAM_ADDR  output  18  SRAM half-word address.
REQ-013 SRAM_DQ_out  output  16  write data to SRAM.
REQ-014 SRAM_DQ_in  input  16  read data from SRAM.
REQ-015 SRAM_DQ_oe  output  1  1 = controller drives DQ.
REQ-016 SRAM_WE_N  output  1  active-low write strobe; SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N outputs 1 each, active-low.

Function
REQ-017 FSM states SHALL be IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE.
REQ-018 IDLE: rd_en=1 -> RD_LO; wr_en=1 -> WR_LO; both high -> WR_LO (write priority); neither -> stay.
REQ-019 Each of RD_LO, RD_HI, WR_LO, WR_HI SHALL last exactly ACCESS_CYCLES cycles, tracked by 4-bit wait counter reset to 0 on state entry; LO -> HI, HI -> DONE.
REQ-020 DONE SHALL last one cycle, then IDLE unconditionally.
REQ-021 ready = 1 when (rd_en|wr_en)=0 or state=DONE; otherwise 0 (combinational).
REQ-022 Total load/store latency: ready high in cycle 1+2*ACCESS_CYCLES counted from first request cycle as cycle 0 (default: cycle 5).
REQ-023 word = (address - DATA_BASE) >> 2, 32-bit modular; SRAM_ADDR = {word[16:0],0} in *_LO, {word[16:0],1} in *_HI; upper bits discarded.
REQ-024 address and write_data SHALL be registered on IDLE exit; later input changes do not affect the access.
REQ-025 WR_LO drives write_data[15:0], WR_HI drives write_data[31:16]; SRAM_DQ_oe=1 and SRAM_WE_N=0 throughout both states, else oe=0, WE_N=1.
REQ-026 RD_LO/RD_HI: SRAM_OE_N=0; SRAM_DQ_in captured into read_data[15:0]/[31:16] on last cycle of respective state.
REQ-027 read_data valid in DONE, held unchanged until next read captures; writes do not alter it.
REQ-028 SRAM_CE_N, SRAM_UB_N, SRAM_LB_N = 0 in all non-IDLE, non-DONE states; 1 otherwise.
REQ-029 Request deasserted mid-access: access SHALL still complete to DONE; ready then follows REQ-021.
REQ-030 Back-to-back: request present in cycle after DONE starts new access from IDLE (one idle cycle between accesses).

Reset
REQ-031 rst=1 at any time (incl. mid-access): state=IDLE, counter=0, read_data=0, SRAM_ADDR=0, SRAM_DQ_out=0, SRAM_DQ_oe=0, all active-low strobes=1, captured address/data=0.
REQ-032 No partial write completes after reset; next access restarts from IDLE.

Structure
REQ-033 Shared package SHALL hold state enumeration and DATA_BASE default.
REQ-034 Single module; no sub-module is natural.

Verification
REQ-035 Write address 1024, data 32'hDEADBEEF -> SRAM_ADDR 0 DQ_out 16'hBEEF, then 1 DQ_out 16'hDEAD, WE_N=0 two cycles each, ready high cycle 5.
REQ-036 Read address 1032 with model returning 16'h5678 then 16'h1234 -> SRAM_ADDR 4,5; read_data 32'h12345678, ready high cycle 5.
REQ-037 No request -> ready=1, SRAM_WE_N=1, SRAM_DQ_oe=0, state IDLE indefinitely.
REQ-038 rd_en and wr_en both high, address 1028 -> write to SRAM_ADDR 2,3; read_data unchanged.
REQ-039 rst pulse in WR_HI cycle 1 -> WE_N=1, oe=0 immediately, ready=0 while request held, new access restarts at SRAM_ADDR 0-based LO half.
REQ-040 ACCESS_CYCLES=1, two back-to-back reads -> ready high cycles 3 and 7.
